vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- CLK_DIV, 2, clk cycles per pixel; even, >=2.
- HSYNC_POL, 0, active level of hsync.
- VSYNC_POL, 0, active level of vsync.
- N_MODES, 4, display modes selectable by nxt; >=2.
- DEB_CYCLES, 1000000, debounce stability window in clk cycles.
REQ-002 Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL); MW = clog2(N_MODES).
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, 50 MHz board clock; sole clock.
- rst_n_btn, in, 1, asynchronous active-low reset.
- nxt, in, 1, raw pushbutton, active-low, asynchronous to clk.
- vgaclk, out, 1, pixel clock to DAC: clk/CLK_DIV, 50% duty.
- hsync, out, 1, horizontal sync at HSYNC_POL when active.
- vsync, out, 1, vertical sync at VSYNC_POL when active.
- sync_b, out, 1, composite sync to DAC; constant 0.
- blank_b, out, 1, 1 inside the visible area.
- x, out, XW, current horizontal pixel count.
- y, out, YW, current line count.
- frame_start, out, 1, one-clk pulse on wrap to (0,0).
- mode, out, MW, active display mode.

Function
REQ-004 Pixel enable pe: pulse for 1 clk every CLK_DIV clk cycles from a free-running divider; vgaclk is registered, low for CLK_DIV/2 clks and high for CLK_DIV/2 clks; pe coincides with the vgaclk falling edge.
REQ-005 Counters advance only on pe; x counts 0..H_TOTAL-1 then wraps to 0; y increments when x wraps and itself wraps V_TOTAL-1 -> 0.
REQ-006 hsync = HSYNC_POL while x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HSYNC_POL; vsync uses the same rule with y, V_* and VSYNC_POL.
REQ-007 blank_b = 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-008 hsync, vsync and blank_b are registered and update on the same clk edge as x/y; they are decoded from the new x/y values, with zero skew between them.
REQ-009 frame_start = 1 for exactly the one clk in which x,y transition from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-010 nxt passes through a 2-flop synchroniser before any use.
REQ-011 Debounce FSM states: REL, PRESS_CHK, HELD, REL_CHK.
- REL -> PRESS_CHK when synced nxt = 0.
- PRESS_CHK -> HELD after DEB_CYCLES consecutive clks with nxt = 0; returns to REL on any 1.
- HELD -> REL_CHK when synced nxt = 1.
- REL_CHK -> REL after DEB_CYCLES consecutive clks with nxt = 1; returns to HELD on any 0.
REQ-012 Entry into HELD increments the register pending, modulo N_MODES (N_MODES-1 -> 0); there is exactly one increment per accepted press.
REQ-013 mode <= pending only in the clk where frame_start = 1, so mode never changes mid-frame.
REQ-014 Multiple accepted presses in one frame accumulate in pending; mode then jumps directly to the accumulated value.
REQ-015 If a press is accepted in the same clk as frame_start, mode takes the pre-increment pending value; the increment applies at the next frame.

Reset
REQ-016 While rst_n_btn = 0, asynchronously:
- divider, x, y = 0; vgaclk = 0; frame_start = 0.
- hsync = ~HSYNC_POL; vsync = ~VSYNC_POL; blank_b = 0.
- mode, pending = 0; FSM = REL; debounce counter = 0; synchroniser flops = 1.
REQ-017 After reset release, the first pe occurs on the CLK_DIV-th rising clk edge. Reset asserted mid-frame or mid-debounce discards all progress; no mode increment results.

Verification
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CLK_DIV=2; N_MODES=4; DEB_CYCLES=4.
REQ-018 Release reset, run 256 clks -> x wraps 15->0 every 32 clks; frame_start pulses exactly once at clk 256; vgaclk period is 2 clks.
REQ-019 Line scan -> hsync = 0 exactly for x = 10..12; blank_b = 1 only for x 0..7 with y 0..3; vsync = 0 only for y = 5..6.
REQ-020 nxt held low for 3 clks, then high -> no increment, mode stays 0. nxt held low for 10 clks -> pending = 1; mode stays 0 until the next frame_start, then mode = 1.
REQ-021 Four accepted presses, each with 10 clks low and 10 clks high -> pending sequence 1, 2, 3, 0 (wrap); with all four inside one frame, mode goes 0 -> 0 at that frame boundary.
REQ-022 Assert rst_n_btn at x=5, y=2 with the FSM in PRESS_CHK -> all outputs take REQ-016 values immediately; after release, counting restarts from (0,0) and mode = 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a pixel-clock divider, registered sync/blank decode,
// and a debounced "next mode" pushbutton whose effect is deferred to the frame boundary.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int N_MODES    = 4,
    parameter int DEB_CYCLES = 1000000,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL),
    localparam int MW        = $clog2(N_MODES)
) (
    input  logic          clk,
    input  logic          rst_n_btn,
    input  logic          nxt,
    output logic          vgaclk,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic [MW-1:0] mode
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEB_CYCLES) + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [XW-1:0] X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT     = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT     = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_START  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [MW-1:0] MODE_LAST = MW'(N_MODES - 1);

    typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} deb_state_t;

    logic [DW-1:0] div_q, div_d;
    logic          pe;
    logic          vgaclk_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic          fs_q, wrap;
    logic          sync1_q, sync2_q;
    deb_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [MW-1:0] pending_q, pending_inc;
    logic [MW-1:0] mode_q;

    // Timing datapath: sync/blank are decoded from the next-state counters so they
    // land on the same edge as x/y with no skew.
    always_comb begin
        pe      = (div_q == DIV_LAST);
        div_d   = pe ? '0 : div_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        wrap    = 1'b0;
        if (pe) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                y_d  = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                wrap = (y_q == Y_LAST);
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        hsync_d = (x_d >= HS_START && x_d <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (y_d >= VS_START && y_d <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
        blank_d = (x_d < X_ACT) && (y_d < Y_ACT);
    end

    always_ff @(posedge clk or negedge rst_n_btn) begin
        if (!rst_n_btn) begin
            div_q    <= '0;
            vgaclk_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            blank_q  <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            vgaclk_q <= (div_d >= DIV_HALF);
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            fs_q     <= wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n_btn) begin
        if (!rst_n_btn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= nxt;
            sync2_q <= sync1_q;
        end
    end

    assign pending_inc = (pending_q == MODE_LAST) ? '0 : pending_q + 1'b1;

    // Debounce FSM; mode only samples pending on the frame_start clock, so a press
    // accepted in that same clock is seen one frame later.
    always_ff @(posedge clk or negedge rst_n_btn) begin
        if (!rst_n_btn) begin
            state_q   <= REL;
            cnt_q     <= '0;
            pending_q <= '0;
            mode_q    <= '0;
        end else begin
            if (fs_q) begin
                mode_q <= pending_q;
            end
            case (state_q)
                REL: begin
                    cnt_q <= '0;
                    if (!sync2_q) state_q <= PRESS_CHK;
                end
                PRESS_CHK: begin
                    if (sync2_q) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= HELD;
                        cnt_q     <= '0;
                        pending_q <= pending_inc;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    cnt_q <= '0;
                    if (sync2_q) state_q <= REL_CHK;
                end
                REL_CHK: begin
                    if (!sync2_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign vgaclk      = vgaclk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign sync_b      = 1'b0;
    assign blank_b     = blank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign mode        = mode_q;

endmodule
